divide_r_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined restoring fraction divider (STAGES stages, fixed throughput of one operation per cycle, no stall input) among NREQ requesters.
- Registers the operands of the granted request into the divider inputs and tracks each in-flight operation with a valid/tag shift register.
- Captures the divider result into a result FIFO. Credit-based issue guarantees that no result is ever dropped, because the divider pipeline cannot be stalled.
- Sits between the FPU divide/sqrt front-ends and the shared mantissa divider.

---
 rtl/divr_sched_pkg.sv | 42 ++++
 rtl/divr_sched_fifo.sv | 61 ++++++
 rtl/divide_r_sched.sv | 219 +++++++++++++++++++++
 tb/tb_divide_r_sched.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divr_sched_pkg.sv
// -----------------------------------------------------------------------------
// divr_sched_pkg
// Shared definitions for the divide_r_sched scheduler and its result FIFO.
//   clog2    : constant ceil(log2) used for pointer, count and source widths.
//   tag_w    : width of the per-operation tag carried alongside the divider.
//   entry_w  : width of one result FIFO entry.
// Tag layout (LSB first): dz flag, [range flag], src index.
// FIFO entry layout (LSB first): quot[WIDTH], sticky, dz, src[SRC_W], [range].
// SRC_W itself is clog2(NREQ) and is derived inside each module, because
// NREQ is a module parameter.
// Optional feature macro: DIVR_SCHED_RANGE_CHK_EN adds the range flag.
// -----------------------------------------------------------------------------
package divr_sched_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int TAG_DZ_BIT = 0;

`ifdef DIVR_SCHED_RANGE_CHK_EN
  localparam int TAG_RNG_BIT = 1;
  localparam int TAG_FLAG_W  = 2;
`else
  localparam int TAG_FLAG_W  = 1;
`endif

  function automatic int tag_w(input int src_w);
    return src_w + TAG_FLAG_W;
  endfunction

  // quot + sticky + flags + src
  function automatic int entry_w(input int width, input int src_w);
    return width + 1 + TAG_FLAG_W + src_w;
  endfunction

endpackage

// File: rtl/divr_sched_fifo.sv
// -----------------------------------------------------------------------------
// divr_sched_fifo
// Synchronous result FIFO with a combinational head (first-word fall-through).
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears storage too,
//                  so the head reads zero after reset).
//   push         : write push_data this cycle; the caller guarantees room.
//   push_data    : entry to store.
//   pop          : remove the head entry; ignored when empty.
//   head_data    : current head entry, stable until popped.
//   head_valid   : FIFO holds at least one entry.
//   count        : number of stored entries.
// -----------------------------------------------------------------------------
module divr_sched_fifo
  import divr_sched_pkg::*;
#(
  parameter int DW    = 11,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DW-1:0]               push_data,
  input  logic                        pop,
  output logic [DW-1:0]               head_data,
  output logic                        head_valid,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;

  assign pop_ok     = pop && (count != '0);
  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      if (push && !pop_ok) count <= count + CW'(1);
      else if (!push && pop_ok) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/divide_r_sched.sv
// -----------------------------------------------------------------------------
// divide_r_sched
// Round-robin scheduler sharing one non-stallable pipelined fraction divider
// (STAGES deep, one op per cycle) among NREQ requesters. Each issued op is
// tracked by a valid/tag shift register; its result lands in a result FIFO.
// Issue is credit based (FIFO entries + ops in flight < FIFO_DEPTH) so a
// result arriving from the divider always finds room.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Requester r holds req_valid[r] and its operands stable until
// req_ready[r]; it may also withdraw without a grant. req_ready is one-hot or
// zero. On the result side res_* are held stable while res_valid && !res_ready.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset.
//   req_valid/req_ready : per-requester request handshake.
//   req_num/req_den     : packed operands, requester r at [r*WIDTH +: WIDTH].
//   div_num/div_den     : registered operands to the divider.
//   div_quot/div_sticky : divider last-stage outputs (combinational).
//   res_valid/res_ready : result handshake.
//   res_quot/res_sticky : quotient and remainder-nonzero flag.
//   res_dz              : denominator was zero (quot forced to all ones).
//   res_range_err       : num > den at issue (only with DIVR_SCHED_RANGE_CHK_EN).
//   res_src             : originating requester index.
//   busy                : ops in flight or results waiting.
// Optional feature macro: DIVR_SCHED_RANGE_CHK_EN.
// -----------------------------------------------------------------------------
module divide_r_sched
  import divr_sched_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STAGES     = 6,
  parameter int NREQ       = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_num,
  input  logic [NREQ*WIDTH-1:0]     req_den,
  output logic [WIDTH-1:0]          div_num,
  output logic [WIDTH-1:0]          div_den,
  input  logic [WIDTH-1:0]          div_quot,
  input  logic                      div_sticky,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [WIDTH-1:0]          res_quot,
  output logic                      res_sticky,
  output logic                      res_dz,
`ifdef DIVR_SCHED_RANGE_CHK_EN
  output logic                      res_range_err,
`endif
  output logic [clog2(NREQ)-1:0]    res_src,
  output logic                      busy
);

  localparam int SRC_W = clog2(NREQ);
  localparam int TAG_W = tag_w(SRC_W);
  localparam int EW    = entry_w(WIDTH, SRC_W);
  localparam int ICW   = clog2(STAGES + 1);
  localparam int FCW   = clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] num_arr [NREQ];
  logic [WIDTH-1:0] den_arr [NREQ];
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_any;
  logic             credit;
  logic             issue;
  logic [WIDTH-1:0] issue_num;
  logic [WIDTH-1:0] issue_den;
  logic [TAG_W-1:0] issue_tag;

  logic [STAGES-1:0] inflight_valid;
  logic [TAG_W-1:0]  tag_sr [STAGES];
  logic [ICW-1:0]    inflight_count;
  logic [FCW-1:0]    fifo_count;

  logic [TAG_W-1:0]  out_tag;
  logic              push;
  logic [WIDTH-1:0]  r_quot;
  logic              r_sticky;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     head_data;
  logic              pop;

  // ---------------------------------------------------------------------------
  // Request side: unpack operands, round-robin search upward from ptr.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      num_arr[r] = req_num[r*WIDTH +: WIDTH];
      den_arr[r] = req_den[r*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    logic [SRC_W:0] cand;
    cand      = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (SRC_W+1)'(i);
      if (cand >= (SRC_W+1)'(NREQ)) cand = cand - (SRC_W+1)'(NREQ);
      if (!grant_any && req_valid[cand[SRC_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight_count = inflight_count + ICW'(inflight_valid[i]);
    end
  end

  // The count used here is the registered one, so a pop in this same cycle
  // does not free a credit; this keeps res_ready out of the req_ready path.
  assign credit    = (int'(fifo_count) + int'(inflight_count)) < FIFO_DEPTH;
  assign issue     = grant_any && credit && !rst;
  assign req_ready = issue ? (NREQ'(1) << grant_idx) : '0;
  assign issue_num = num_arr[grant_idx];
  assign issue_den = den_arr[grant_idx];

  always_comb begin
    issue_tag                        = '0;
    issue_tag[TAG_DZ_BIT]            = (issue_den == '0);
`ifdef DIVR_SCHED_RANGE_CHK_EN
    issue_tag[TAG_RNG_BIT]           = (issue_num > issue_den);
`endif
    issue_tag[TAG_W-1 -: SRC_W]      = grant_idx;
  end

  // ---------------------------------------------------------------------------
  // Divider operand registers, valid/tag shift register, round-robin pointer.
  // Tags move unconditionally; only the valid bits decide what is real, so
  // stale divider contents after reset are never captured.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= '0;
      div_num        <= '0;
      div_den        <= '0;
      inflight_valid <= '0;
      for (int i = 0; i < STAGES; i++) tag_sr[i] <= '0;
    end else begin
      inflight_valid <= {inflight_valid[STAGES-2:0], issue};
      tag_sr[0]      <= issue_tag;
      for (int i = 1; i < STAGES; i++) tag_sr[i] <= tag_sr[i-1];
      if (issue) begin
        div_num <= issue_num;
        div_den <= issue_den;
        ptr     <= (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + SRC_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result side. Divide-by-zero overrides everything, including range error.
  // ---------------------------------------------------------------------------
  assign out_tag = tag_sr[STAGES-1];
  assign push    = inflight_valid[STAGES-1];

  always_comb begin
    r_quot   = div_quot;
    r_sticky = div_sticky;
`ifdef DIVR_SCHED_RANGE_CHK_EN
    if (out_tag[TAG_RNG_BIT]) begin
      r_quot   = '0;
      r_sticky = 1'b1;
    end
`endif
    if (out_tag[TAG_DZ_BIT]) begin
      r_quot   = '1;
      r_sticky = 1'b0;
    end
  end

  always_comb begin
    push_data                       = '0;
    push_data[WIDTH-1:0]            = r_quot;
    push_data[WIDTH]                = r_sticky;
    push_data[WIDTH+1]              = out_tag[TAG_DZ_BIT];
    push_data[WIDTH+2 +: SRC_W]     = out_tag[TAG_W-1 -: SRC_W];
`ifdef DIVR_SCHED_RANGE_CHK_EN
    push_data[EW-1]                 = out_tag[TAG_RNG_BIT];
`endif
  end

  assign pop = res_valid && res_ready;

  divr_sched_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (res_valid),
    .count      (fifo_count)
  );

  assign res_quot   = head_data[WIDTH-1:0];
  assign res_sticky = head_data[WIDTH];
  assign res_dz     = head_data[WIDTH+1];
  assign res_src    = head_data[WIDTH+2 +: SRC_W];
`ifdef DIVR_SCHED_RANGE_CHK_EN
  assign res_range_err = head_data[EW-1];
`endif

  assign busy = (|inflight_valid) || (fifo_count != '0);

endmodule

// File: tb/tb_divide_r_sched.sv
// -----------------------------------------------------------------------------
// tb_divide_r_sched
// Self-checking bench for divide_r_sched (WIDTH=8, STAGES=6, NREQ=2,
// FIFO_DEPTH=8). Includes a behavioural 6-stage Q1.7 fraction divider.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the
// falling edge. Define DIVR_SCHED_RANGE_CHK_EN to build the range-check variant.
// -----------------------------------------------------------------------------
module tb_divide_r_sched;

  localparam int WIDTH      = 8;
  localparam int STAGES     = 6;
  localparam int NREQ       = 2;
  localparam int FIFO_DEPTH = 8;
`ifdef DIVR_SCHED_RANGE_CHK_EN
  localparam int EW = 12;
`else
  localparam int EW = 11;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_num = '0;
  logic [NREQ*WIDTH-1:0] req_den = '0;
  logic [WIDTH-1:0]      div_num, div_den, div_quot;
  logic                  div_sticky;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic [WIDTH-1:0]      res_quot;
  logic                  res_sticky, res_dz;
  logic [0:0]            res_src;
  logic                  busy;
`ifdef DIVR_SCHED_RANGE_CHK_EN
  logic                  res_range_err;
`endif

  divide_r_sched #(
    .WIDTH(WIDTH), .STAGES(STAGES), .NREQ(NREQ), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_den(req_den),
    .div_num(div_num), .div_den(div_den),
    .div_quot(div_quot), .div_sticky(div_sticky),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_quot(res_quot), .res_sticky(res_sticky), .res_dz(res_dz),
`ifdef DIVR_SCHED_RANGE_CHK_EN
    .res_range_err(res_range_err),
`endif
    .res_src(res_src), .busy(busy)
  );

  // ---------------- divider model ----------------
  // div_num registered at edge k; STAGES-1 more register stages; last stage
  // combinational, so the quotient is valid just before edge k+STAGES.
  logic [WIDTH-1:0] pn [STAGES-1];
  logic [WIDTH-1:0] pd [STAGES-1];
  always @(posedge clk) begin
    pn[0] <= div_num;
    pd[0] <= div_den;
    for (int i = 1; i < STAGES-1; i++) begin
      pn[i] <= pn[i-1];
      pd[i] <= pd[i-1];
    end
  end
  always_comb begin
    logic [14:0] dvd;
    dvd        = {pn[STAGES-2], 7'b0};
    div_quot   = 8'h5A;
    div_sticky = 1'b1;
    if (pd[STAGES-2] != 8'h00) begin
      div_quot   = 8'(dvd / {7'b0, pd[STAGES-2]});
      div_sticky = (dvd % {7'b0, pd[STAGES-2]}) != 15'd0;
    end
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int n_grants = 0;
  int n_pops = 0;
  logic [EW-1:0] exp_q[$];
  int            gnt_log[$];
  logic [1:0]    gnt_s = '0;
  logic [7:0]    q0_num[$], q0_den[$], q1_num[$], q1_den[$];
  logic [EW-1:0] act;

`ifdef DIVR_SCHED_RANGE_CHK_EN
  assign act = {res_range_err, res_src, res_dz, res_sticky, res_quot};
`else
  assign act = {res_src, res_dz, res_sticky, res_quot};
`endif

  // Expected result: Q1.7 quotient floor(num*128/den), sticky = remainder != 0.
  function automatic logic [EW-1:0] model(input logic [7:0] n, input logic [7:0] d,
                                          input logic src);
    logic [14:0] dvd;
    logic [7:0]  q;
    logic        s;
    logic        dz;
    dvd = {n, 7'b0};
    dz  = (d == 8'h00);
    if (dz) begin
      q = 8'hFF;
      s = 1'b0;
    end
`ifdef DIVR_SCHED_RANGE_CHK_EN
    else if (n > d) begin
      q = 8'h00;
      s = 1'b1;
    end
`endif
    else begin
      q = 8'(dvd / {7'b0, d});
      s = (dvd % {7'b0, d}) != 15'd0;
    end
`ifdef DIVR_SCHED_RANGE_CHK_EN
    return {(n > d), src, dz, s, q};
`else
    return {src, dz, s, q};
`endif
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      gnt_s = '0;
    end else begin
      gnt_s = req_valid & req_ready;
      for (int r = 0; r < NREQ; r++) begin
        if (gnt_s[r]) begin
          exp_q.push_back(model(req_num[r*8 +: 8], req_den[r*8 +: 8], 1'(r)));
          gnt_log.push_back(r);
          n_grants++;
        end
      end
      if (res_valid && res_ready) begin
        logic [EW-1:0] e;
        n_pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_pop: got %h, required no result (queue empty)", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL scoreboard_result: got %h, required %h", act, e);
          end
        end
      end
    end
  end

  // ---------------- requester driver ----------------
  always @(posedge clk) begin
    #1;
    if (gnt_s[0] && q0_num.size() != 0) begin q0_num.delete(0); q0_den.delete(0); end
    if (gnt_s[1] && q1_num.size() != 0) begin q1_num.delete(0); q1_den.delete(0); end
    req_valid[0]  = q0_num.size() != 0;
    req_num[7:0]  = (q0_num.size() != 0) ? q0_num[0] : 8'h00;
    req_den[7:0]  = (q0_den.size() != 0) ? q0_den[0] : 8'h00;
    req_valid[1]  = q1_num.size() != 0;
    req_num[15:8] = (q1_num.size() != 0) ? q1_num[0] : 8'h00;
    req_den[15:8] = (q1_den.size() != 0) ? q1_den[0] : 8'h00;
  end

  task automatic add_op(input int r, input logic [7:0] n, input logic [7:0] d);
    if (r == 0) begin q0_num.push_back(n); q0_den.push_back(d); end
    else        begin q1_num.push_back(n); q1_den.push_back(d); end
  endtask

  task automatic add_rand_op(input int r);
    logic [7:0] d;
    logic [7:0] n;
    d = 8'($urandom_range(1, 255));
    n = 8'($urandom_range(0, int'(d)));
    if ($urandom_range(0, 7) == 0) begin d = 8'h00; n = 8'h00; end
    add_op(r, n, d);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (n < 400 && !(exp_q.size() == 0 && q0_num.size() == 0 && q1_num.size() == 0
                        && !busy && !res_valid)) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_drain: busy=%0b pending=%0d, required idle within 400 cycles",
               name, busy, exp_q.size());
    end
  endtask

  task automatic wait_res(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL %s_timeout: res_valid=0, required 1 within 40 cycles", name);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 9;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b, required 00", req_ready); end
    if (div_num !== 8'h00) begin errors++; $display("FAIL rst_div_num: got %h, required 00", div_num); end
    if (div_den !== 8'h00) begin errors++; $display("FAIL rst_div_den: got %h, required 00", div_den); end
    if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b, required 0", res_valid); end
    if (res_quot !== 8'h00) begin errors++; $display("FAIL rst_res_quot: got %h, required 00", res_quot); end
    if (res_sticky !== 1'b0) begin errors++; $display("FAIL rst_res_sticky: got %b, required 0", res_sticky); end
    if (res_dz !== 1'b0) begin errors++; $display("FAIL rst_res_dz: got %b, required 0", res_dz); end
    if (res_src !== 1'b0) begin errors++; $display("FAIL rst_res_src: got %b, required 0", res_src); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int g_cyc;
    int n;
    int lat;
    g_cyc = -1;
    n = 0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    add_op(0, 8'h40, 8'h80);
    while (g_cyc < 0 && n < 20) begin
      @(negedge clk);
      if (req_ready[0]) g_cyc = cyc + 1;
      n++;
    end
    checks++;
    if (g_cyc < 0) begin errors++; $display("FAIL single_grant: no grant, required grant to r0"); end
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    lat = cyc - g_cyc;
    checks += 5;
    if (lat != 6) begin errors++; $display("FAIL single_latency: got %0d cycles, required 6", lat); end
    if (res_quot !== 8'h40) begin errors++; $display("FAIL single_quot: got %h, required 40", res_quot); end
    if (res_sticky !== 1'b0) begin errors++; $display("FAIL single_sticky: got %b, required 0", res_sticky); end
    if (res_dz !== 1'b0) begin errors++; $display("FAIL single_dz: got %b, required 0", res_dz); end
    if (res_src !== 1'b0) begin errors++; $display("FAIL single_src: got %b, required 0", res_src); end
    wait_idle("single");
  endtask

  task automatic test_values();
    @(posedge clk); #1;
    res_ready = 1'b1;
    add_op(1, 8'h20, 8'h60);
    wait_res("third");
    checks += 4;
    if (res_quot !== 8'h2A) begin errors++; $display("FAIL third_quot: got %h, required 2a", res_quot); end
    if (res_sticky !== 1'b1) begin errors++; $display("FAIL third_sticky: got %b, required 1", res_sticky); end
    if (res_dz !== 1'b0) begin errors++; $display("FAIL third_dz: got %b, required 0", res_dz); end
    if (res_src !== 1'b1) begin errors++; $display("FAIL third_src: got %b, required 1", res_src); end
    wait_idle("third");

    @(posedge clk); #1;
    add_op(0, 8'h00, 8'h00);
    wait_res("divzero");
    checks += 4;
    if (res_quot !== 8'hFF) begin errors++; $display("FAIL divzero_quot: got %h, required ff", res_quot); end
    if (res_sticky !== 1'b0) begin errors++; $display("FAIL divzero_sticky: got %b, required 0", res_sticky); end
    if (res_dz !== 1'b1) begin errors++; $display("FAIL divzero_dz: got %b, required 1", res_dz); end
    if (res_src !== 1'b0) begin errors++; $display("FAIL divzero_src: got %b, required 0", res_src); end
    wait_idle("divzero");

    // Random traffic with a random consumer; the scoreboard checks every result.
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      res_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) add_rand_op(0);
      if ($urandom_range(0, 2) == 0) add_rand_op(1);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle("random");
  endtask

  task automatic test_back_to_back();
    int n;
    int bad;
    logic [1:0] prev;
    @(posedge clk); #1;
    res_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin add_rand_op(0); add_rand_op(1); end
    n = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && n < 20) begin @(negedge clk); n++; end
    bad = 0;
    prev = 2'b00;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (!$onehot(req_ready) || (i > 0 && req_ready == prev)) begin
        bad++;
        $display("FAIL b2b_grant: cycle %0d got %b after %b, required alternating one-hot",
                 i, req_ready, prev);
      end
      prev = req_ready;
    end
    checks++;
    if (bad != 0) errors++;
    wait_idle("b2b");
  endtask

  task automatic test_stall();
    int g0;
    int g1;
    int p0;
    logic [EW-1:0] held;
    p0 = n_pops;
    @(posedge clk); #1;
    res_ready = 1'b0;
    g0 = n_grants;
    for (int i = 0; i < 12; i++) begin add_rand_op(0); add_rand_op(1); end
    repeat (30) @(negedge clk);
    #1;
    checks += 3;
    if (n_grants - g0 != 8) begin errors++; $display("FAIL stall_grants: got %0d, required 8", n_grants - g0); end
    if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready: got %b, required 00", req_ready); end
    if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_res_valid: got %b, required 1", res_valid); end
    held = act;
    repeat (3) @(negedge clk);
    checks++;
    if (act !== held) begin errors++; $display("FAIL stall_hold: got %h, required %h", act, held); end
    @(posedge clk); #1;
    res_ready = 1'b1;
    g1 = n_grants;
    repeat (25) @(negedge clk);
    #1;
    checks++;
    if (n_grants <= g1) begin errors++; $display("FAIL stall_resume: got %0d new grants, required >0", n_grants - g1); end
    wait_idle("stall");
    checks++;
    if (n_pops - p0 != 24) begin errors++; $display("FAIL stall_pops: got %0d, required 24", n_pops - p0); end
  endtask

  task automatic test_reset_mid();
    int g0;
    int n;
    int bad;
    @(posedge clk); #1;
    res_ready = 1'b1;
    g0 = n_grants;
    for (int i = 0; i < 4; i++) add_rand_op(0);
    n = 0;
    while (n_grants < g0 + 4 && n < 30) begin @(negedge clk); #1; n++; end
    checks += 2;
    if (n_grants != g0 + 4) begin errors++; $display("FAIL midrst_issue: got %0d grants, required 4", n_grants - g0); end
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b, required 1", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b, required 0", busy); end
    if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_res_valid: got %b, required 0", res_valid); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_stale: got %0d cycles with res_valid, required 0", bad); end
    gnt_log.delete();
    @(posedge clk); #1;
    add_op(0, 8'h10, 8'h20);
    add_op(1, 8'h30, 8'h40);
    n = 0;
    while (gnt_log.size() == 0 && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (gnt_log.size() == 0) begin
      errors++;
      $display("FAIL midrst_first_grant: got none, required r0");
    end else if (gnt_log[0] != 0) begin
      errors++;
      $display("FAIL midrst_first_grant: got r%0d, required r0", gnt_log[0]);
    end
    wait_idle("midrst");
  endtask

`ifdef DIVR_SCHED_RANGE_CHK_EN
  task automatic test_range();
    @(posedge clk); #1;
    res_ready = 1'b1;
    add_op(0, 8'h90, 8'h80);
    wait_res("range");
    checks += 3;
    if (res_range_err !== 1'b1) begin errors++; $display("FAIL range_err: got %b, required 1", res_range_err); end
    if (res_quot !== 8'h00) begin errors++; $display("FAIL range_quot: got %h, required 00", res_quot); end
    if (res_sticky !== 1'b1) begin errors++; $display("FAIL range_sticky: got %b, required 1", res_sticky); end
    wait_idle("range");
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_values();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef DIVR_SCHED_RANGE_CHK_EN
    test_range();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
